// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin N-port data-memory arbiter onto one shared bus.
// Define DMEM_ARB_TIMEOUT_EN to add the bus watchdog.
module dmem_arbiter #(
   parameter int NCORES     = 2,
   parameter int RW         = 16,
   parameter int ADDR_BYTES = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic [NCORES-1:0]              c_mem_req,
   input  logic [NCORES-1:0]              c_mem_we,
   input  logic [NCORES*RW-1:0]           c_mem_addr,
   input  logic [NCORES*RW-1:0]           c_mem_data,
   input  logic [NCORES*ADDR_BYTES-1:0]   c_mem_sel,
   output logic [NCORES*RW-1:0]           c_mem_data_o,
   output logic [NCORES-1:0]              c_mem_ack,
   output logic [NCORES-1:0]              c_mem_exception,
   output logic                           o_mem_req,
   output logic                           o_mem_we,
   output logic [RW-1:0]                  o_mem_addr,
   output logic [RW-1:0]                  o_mem_data,
   output logic [ADDR_BYTES-1:0]          o_mem_sel,
   input  logic [RW-1:0]                  i_mem_data,
   input  logic                           i_mem_ack,
   input  logic                           i_mem_exception,
   output logic [((NCORES > 1) ? $clog2(NCORES) : 1)-1:0] o_grant
);

   localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_RESP
   } state_t;

   state_t                state_q, state_d;
   logic [GW-1:0]         last_q, last_d;
   logic [GW-1:0]         grant_q, grant_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [RW-1:0]         addr_q, addr_d;
   logic [RW-1:0]         wdata_q, wdata_d;
   logic [ADDR_BYTES-1:0] sel_q, sel_d;
   logic [RW-1:0]         rdata_q, rdata_d;
   logic                  exc_q, exc_d;

   logic                  hi_vld, lo_vld, pick_vld;
   logic [GW-1:0]         hi_idx, lo_idx, pick_idx;

`ifdef DMEM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0]            cnt_q, cnt_d;
`endif

   // Lowest requester above last wins; otherwise wrap to lowest at/below it.
   always_comb begin
      hi_vld = 1'b0;
      hi_idx = '0;
      lo_vld = 1'b0;
      lo_idx = '0;
      for (int k = NCORES - 1; k >= 0; k--) begin
         if (c_mem_req[k]) begin
            if (GW'(k) > last_q) begin
               hi_vld = 1'b1;
               hi_idx = GW'(k);
            end else begin
               lo_vld = 1'b1;
               lo_idx = GW'(k);
            end
         end
      end
      pick_vld = hi_vld | lo_vld;
      pick_idx = hi_vld ? hi_idx : lo_idx;
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      grant_d = grant_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      sel_d   = sel_q;
      rdata_d = rdata_q;
      exc_d   = exc_q;
`ifdef DMEM_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (pick_vld) begin
               state_d = S_ISSUE;
               last_d  = pick_idx;
               grant_d = pick_idx;
               req_d   = 1'b1;
               for (int k = 0; k < NCORES; k++) begin
                  if (GW'(k) == pick_idx) begin
                     we_d    = c_mem_we[k];
                     addr_d  = c_mem_addr[k*RW +: RW];
                     wdata_d = c_mem_data[k*RW +: RW];
                     sel_d   = c_mem_sel[k*ADDR_BYTES +: ADDR_BYTES];
                  end
               end
`ifdef DMEM_ARB_TIMEOUT_EN
               cnt_d = '0;
`endif
            end
         end
         S_ISSUE: begin
            if (i_mem_ack || i_mem_exception) begin
               state_d = S_RESP;
               req_d   = 1'b0;
               rdata_d = i_mem_data;
               exc_d   = i_mem_exception;
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               state_d = S_RESP;
               req_d   = 1'b0;
               rdata_d = '0;
               exc_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
`endif
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         last_q  <= GW'(NCORES - 1);
         grant_q <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
`ifdef DMEM_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         rdata_q <= rdata_d;
         exc_q   <= exc_d;
`ifdef DMEM_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Response goes to the grantee only, for the single RESP cycle.
   always_comb begin
      c_mem_ack       = '0;
      c_mem_exception = '0;
      c_mem_data_o    = '0;
      for (int k = 0; k < NCORES; k++) begin
         if (state_q == S_RESP && GW'(k) == grant_q) begin
            c_mem_ack[k]              = 1'b1;
            c_mem_exception[k]        = exc_q;
            c_mem_data_o[k*RW +: RW]  = rdata_q;
         end
      end
   end

   assign o_mem_req  = req_q;
   assign o_mem_we   = we_q;
   assign o_mem_addr = addr_q;
   assign o_mem_data = wdata_q;
   assign o_mem_sel  = sel_q;
   assign o_grant    = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized checks of dmem_arbiter
// against a transaction-level round-robin reference model.
module tb_dmem_arbiter;

   localparam int NC = 3;
   localparam int RW = 16;
   localparam int AB = 2;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic [NC-1:0]     c_mem_req;
   logic [NC-1:0]     c_mem_we;
   logic [NC*RW-1:0]  c_mem_addr;
   logic [NC*RW-1:0]  c_mem_data;
   logic [NC*AB-1:0]  c_mem_sel;
   logic [NC*RW-1:0]  c_mem_data_o;
   logic [NC-1:0]     c_mem_ack;
   logic [NC-1:0]     c_mem_exception;
   logic              o_mem_req;
   logic              o_mem_we;
   logic [RW-1:0]     o_mem_addr;
   logic [RW-1:0]     o_mem_data;
   logic [AB-1:0]     o_mem_sel;
   logic [RW-1:0]     i_mem_data;
   logic              i_mem_ack;
   logic              i_mem_exception;
   logic [1:0]        o_grant;

   dmem_arbiter #(
      .NCORES(NC), .RW(RW), .ADDR_BYTES(AB), .TIMEOUT(255)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .c_mem_req(c_mem_req), .c_mem_we(c_mem_we),
      .c_mem_addr(c_mem_addr), .c_mem_data(c_mem_data),
      .c_mem_sel(c_mem_sel), .c_mem_data_o(c_mem_data_o),
      .c_mem_ack(c_mem_ack), .c_mem_exception(c_mem_exception),
      .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
      .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
      .o_mem_sel(o_mem_sel), .i_mem_data(i_mem_data),
      .i_mem_ack(i_mem_ack), .i_mem_exception(i_mem_exception),
      .o_grant(o_grant)
   );

   always #5 i_clk = ~i_clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending requests per core and the last grantee.
   bit [NC-1:0]   pend;
   logic          p_we   [NC];
   logic [RW-1:0] p_addr [NC];
   logic [RW-1:0] p_data [NC];
   logic [AB-1:0] p_sel  [NC];
   int            waited [NC];
   int            model_last;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic new_req(input int k, input logic we, input logic [RW-1:0] a,
                          input logic [RW-1:0] d, input logic [AB-1:0] s);
      pend[k]   = 1'b1;
      p_we[k]   = we;
      p_addr[k] = a;
      p_data[k] = d;
      p_sel[k]  = s;
      waited[k] = 0;
   endtask

   task automatic new_rand(input int k);
      new_req(k, 1'($urandom), RW'($urandom), RW'($urandom), AB'($urandom));
   endtask

   task automatic drive_all();
      for (int k = 0; k < NC; k++) begin
         c_mem_req[k]           = pend[k];
         c_mem_we[k]            = p_we[k];
         c_mem_addr[k*RW +: RW] = p_addr[k];
         c_mem_data[k*RW +: RW] = p_data[k];
         c_mem_sel[k*AB +: AB]  = p_sel[k];
      end
   endtask

   task automatic scramble(input int k);
      c_mem_we[k]            = 1'($urandom);
      c_mem_addr[k*RW +: RW] = RW'($urandom);
      c_mem_data[k*RW +: RW] = RW'($urandom);
      c_mem_sel[k*AB +: AB]  = AB'($urandom);
   endtask

   function automatic int rr_pick();
      for (int i = 1; i <= NC; i++)
         if (pend[(model_last + i) % NC]) return (model_last + i) % NC;
      return -1;
   endfunction

   // Called in an IDLE cycle with requests already driven.
   task automatic do_txn(input int waitc, input bit ack, input bit exc,
                         input logic [RW-1:0] rd, input bit noise,
                         output int g);
      logic [NC-1:0]    exp_ack;
      logic [NC-1:0]    exp_exc;
      logic [NC*RW-1:0] exp_do;
      g = rr_pick();
      i_mem_ack       = 1'($urandom);
      i_mem_exception = 1'b0;
      step();
      chk("bus_req_up", o_mem_req, 1);
      chk("grant", o_grant, g);
      chk("bus_we", o_mem_we, p_we[g]);
      chk("bus_addr", o_mem_addr, p_addr[g]);
      chk("bus_data", o_mem_data, p_data[g]);
      chk("bus_sel", o_mem_sel, p_sel[g]);
      i_mem_ack = 1'b0;
      for (int w = 0; w < waitc; w++) begin
         if (noise) begin
            for (int k = 0; k < NC; k++)
               if (!pend[k] && $urandom_range(0, 3) == 0) new_rand(k);
            drive_all();
            scramble(g);
         end
         step();
         chk("wait_req", o_mem_req, 1);
         chk("wait_addr", o_mem_addr, p_addr[g]);
         chk("wait_data", o_mem_data, p_data[g]);
         chk("wait_sel", o_mem_sel, p_sel[g]);
         chk("wait_noack", c_mem_ack, 0);
      end
      i_mem_ack       = ack;
      i_mem_exception = exc;
      i_mem_data      = rd;
      step();
      exp_ack = '0;
      exp_ack[g] = 1'b1;
      exp_exc = '0;
      exp_exc[g] = exc;
      exp_do = '0;
      exp_do[g*RW +: RW] = rd;
      chk("resp_req_down", o_mem_req, 0);
      chk("resp_ack", c_mem_ack, exp_ack);
      chk("resp_exc", c_mem_exception, exp_exc);
      chk("resp_data", c_mem_data_o, exp_do);
      for (int k = 0; k < NC; k++) begin
         if (k != g && pend[k]) begin
            waited[k]++;
            chk("no_starve", waited[k] <= NC - 1, 1);
         end
      end
      model_last = g;
      pend[g]    = 1'b0;
      waited[g]  = 0;
      drive_all();
      i_mem_ack       = 1'($urandom);
      i_mem_exception = 1'($urandom);
      i_mem_data      = RW'($urandom);
      step();
      chk("idle_ack", c_mem_ack, 0);
      chk("idle_req", o_mem_req, 0);
      i_mem_ack       = 1'b0;
      i_mem_exception = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int  g;
      bit  ack_r, exc_r;
      i_rst           = 1'b1;
      c_mem_req       = '0;
      c_mem_we        = '0;
      c_mem_addr      = '0;
      c_mem_data      = '0;
      c_mem_sel       = '0;
      i_mem_data      = '0;
      i_mem_ack       = 1'b0;
      i_mem_exception = 1'b0;
      pend            = '0;
      model_last      = NC - 1;
      for (int k = 0; k < NC; k++) new_req(k, 1'b0, '0, '0, '0);
      pend = '0;
      step();
      step();
      chk("rst_req", o_mem_req, 0);
      chk("rst_ack", c_mem_ack, 0);
      chk("rst_exc", c_mem_exception, 0);
      chk("rst_data_o", c_mem_data_o, 0);
      chk("rst_grant", o_grant, 0);
      chk("rst_addr", o_mem_addr, 0);
      i_rst = 1'b0;

      // All cores request continuously: order 0,1,2,0,1,2.
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < NC; k++) if (!pend[k]) new_rand(k);
         drive_all();
         do_txn(0, 1'b1, 1'b0, RW'($urandom), 1'b0, g);
         chk("rr_order", g, t % NC);
      end
      pend = '0;
      drive_all();
      step();

      // Single core 0 read, zero-wait memory.
      new_req(0, 1'b0, 16'h1234, 16'h0000, 2'b11);
      drive_all();
      do_txn(0, 1'b1, 1'b0, 16'hBEEF, 1'b0, g);
      chk("single_core", g, 0);

      // Core 1 write held 5 cycles while it changes its address.
      new_req(1, 1'b1, 16'h0040, 16'h00AA, 2'b01);
      drive_all();
      do_txn(5, 1'b1, 1'b0, 16'h5555, 1'b1, g);
      chk("hold_core", g, 1);

      // Exception with ack while others wait, then exception alone.
      new_rand(0);
      new_rand(2);
      drive_all();
      do_txn(1, 1'b1, 1'b1, 16'h0BAD, 1'b0, g);
      chk("exc_core", g, 2);
      drive_all();
      do_txn(2, 1'b0, 1'b1, 16'h0DAD, 1'b0, g);
      chk("exc_only_core", g, 0);

      // Reset while a transaction is in ISSUE.
      pend = '0;
      new_rand(2);
      drive_all();
      step();
      chk("pre_rst_req", o_mem_req, 1);
      chk("pre_rst_grant", o_grant, 2);
      i_rst     = 1'b1;
      i_mem_ack = 1'b1;
      step();
      chk("midrst_req", o_mem_req, 0);
      chk("midrst_ack", c_mem_ack, 0);
      chk("midrst_grant", o_grant, 0);
      chk("midrst_addr", o_mem_addr, 0);
      i_mem_ack  = 1'b0;
      i_rst      = 1'b0;
      model_last = NC - 1;
      for (int k = 0; k < NC; k++) if (!pend[k]) new_rand(k);
      drive_all();
      do_txn(0, 1'b1, 1'b0, RW'($urandom), 1'b0, g);
      chk("post_rst_first", g, 0);

      // Randomized traffic.
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < NC; k++)
            if (!pend[k] && $urandom_range(0, 1) == 1) new_rand(k);
         if (pend == '0) new_rand(int'($urandom_range(0, NC - 1)));
         drive_all();
         ack_r = ($urandom_range(0, 3) != 0);
         exc_r = ($urandom_range(0, 3) == 0);
         if (!ack_r) exc_r = 1'b1;
         do_txn(int'($urandom_range(0, 4)), ack_r, exc_r, RW'($urandom),
                1'b1, g);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
